// File: rtl/run_dump_controller.sv
// run_dump_controller
//   Run controller for R_PipelineCPU. Feeds the CPU's Output_Addr back to its
//   Input_Addr every cycle until the program end is reached. It then idles for a
//   fixed number of drain cycles so that in-flight instructions retire. Finally it
//   reads the register file word by word and streams the words out on a
//   valid/ready port.
//
//   Optional feature: define RUN_WATCHDOG_EN to add a RUN-cycle watchdog. This
//   adds the MAX_RUN_CYCLES parameter and the timeout port.
//
// Ports
//   clk         in   clock, rising edge
//   rst_n       in   asynchronous reset, active low
//   start       in   1-cycle start pulse, honoured in IDLE or DONE only
//   pc_next     in   CPU Output_Addr
//   pc_out      out  CPU Input_Addr
//   rf_raddr    out  register file read address (combinational)
//   rf_rdata    in   register file read data for rf_raddr
//   dump_valid  out  dump_data/dump_index hold a register word
//   dump_ready  in   consumer accepts the word on valid & ready
//   dump_data   out  register value
//   dump_index  out  register number of dump_data
//   busy        out  high in RUN, DRAIN and DUMP
//   done        out  high in DONE
//   timeout     out  watchdog fired (RUN_WATCHDOG_EN only)
module run_dump_controller #(
   parameter int unsigned INSTR_MAX      = 128,
   parameter int unsigned REG_MAX        = 32,
   parameter int unsigned DRAIN_CYCLES   = 4
`ifdef RUN_WATCHDOG_EN
  ,parameter int unsigned MAX_RUN_CYCLES = 1024
`endif
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [31:0] pc_next,
   output logic [31:0] pc_out,
   output logic [4:0]  rf_raddr,
   input  logic [31:0] rf_rdata,
   output logic        dump_valid,
   input  logic        dump_ready,
   output logic [31:0] dump_data,
   output logic [4:0]  dump_index,
   output logic        busy,
   output logic        done
`ifdef RUN_WATCHDOG_EN
  ,output logic        timeout
`endif
);

   typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_DUMP, S_DONE} state_t;

   localparam logic [31:0] PC_LIMIT   = 32'(INSTR_MAX - 4);
   localparam logic [5:0]  IDX_END    = 6'(REG_MAX);
   localparam logic [7:0]  DRAIN_LOAD = 8'(DRAIN_CYCLES);

   state_t      state, state_nxt;
   logic [31:0] pc_nxt;
   logic [7:0]  drain_cnt, drain_nxt;
   logic [5:0]  idx, idx_nxt;     // 6 bits so REG_MAX=32 ends without wrapping
   logic        valid_nxt;
   logic [31:0] data_nxt;
   logic [4:0]  dindex_nxt;

`ifdef RUN_WATCHDOG_EN
   localparam int unsigned RUN_W = $clog2(MAX_RUN_CYCLES + 1);
   localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(MAX_RUN_CYCLES - 1);
   logic [RUN_W-1:0] run_cnt, run_nxt;
   logic             timeout_nxt;
`endif

   assign rf_raddr = (state == S_DUMP) ? idx[4:0] : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         pc_out     <= '0;
         drain_cnt  <= '0;
         idx        <= '0;
         dump_valid <= 1'b0;
         dump_data  <= '0;
         dump_index <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
`ifdef RUN_WATCHDOG_EN
         run_cnt    <= '0;
         timeout    <= 1'b0;
`endif
      end else begin
         state      <= state_nxt;
         pc_out     <= pc_nxt;
         drain_cnt  <= drain_nxt;
         idx        <= idx_nxt;
         dump_valid <= valid_nxt;
         dump_data  <= data_nxt;
         dump_index <= dindex_nxt;
         // busy/done are registered copies of the next state.
         busy       <= state_nxt inside {S_RUN, S_DRAIN, S_DUMP};
         done       <= (state_nxt == S_DONE);
`ifdef RUN_WATCHDOG_EN
         run_cnt    <= run_nxt;
         timeout    <= timeout_nxt;
`endif
      end
   end

   always_comb begin
      state_nxt  = state;
      pc_nxt     = pc_out;
      drain_nxt  = drain_cnt;
      idx_nxt    = idx;
      valid_nxt  = dump_valid;
      data_nxt   = dump_data;
      dindex_nxt = dump_index;
`ifdef RUN_WATCHDOG_EN
      run_nxt     = run_cnt;
      timeout_nxt = timeout;
`endif
      case (state)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_nxt = S_RUN;
               pc_nxt    = '0;
`ifdef RUN_WATCHDOG_EN
               run_nxt     = '0;
               timeout_nxt = 1'b0;
`endif
            end
         end
         S_RUN: begin
            // The limit test uses the current pc_out. A jump past the limit is
            // therefore taken once before the run stops.
            if (pc_out >= PC_LIMIT) begin
               state_nxt = S_DRAIN;
               drain_nxt = DRAIN_LOAD;
            end
`ifdef RUN_WATCHDOG_EN
            else if (run_cnt == RUN_LAST) begin
               state_nxt   = S_DRAIN;
               drain_nxt   = DRAIN_LOAD;
               timeout_nxt = 1'b1;
            end
`endif
            else begin
               pc_nxt = pc_next;
`ifdef RUN_WATCHDOG_EN
               run_nxt = run_cnt + 1'b1;
`endif
            end
         end
         S_DRAIN: begin
            if (drain_cnt == 8'd1) begin
               state_nxt = S_DUMP;
               idx_nxt   = '0;
            end else begin
               drain_nxt = drain_cnt - 8'd1;
            end
         end
         S_DUMP: begin
            // idx == IDX_END means the word on the port is the last one.
            if (dump_valid && dump_ready && (idx == IDX_END)) begin
               valid_nxt = 1'b0;
               state_nxt = S_DONE;
            end else if ((!dump_valid || dump_ready) && (idx < IDX_END)) begin
               valid_nxt  = 1'b1;
               data_nxt   = rf_rdata;
               dindex_nxt = idx[4:0];
               idx_nxt    = idx + 1'b1;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_run_dump_controller.sv
// tb_run_dump_controller
//   Directed bench for run_dump_controller. It models the CPU PC path and a
//   register file whose contents are a fixed function of the register index.
module tb_run_dump_controller;

`ifdef RUN_WATCHDOG_EN
   // Kept above the 32-cycle nominal run so that normal programs never time out.
   localparam int WD = 40;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        dump_ready = 1'b1;
   logic [31:0] pc_next, pc_out, rf_rdata, dump_data;
   logic [4:0]  rf_raddr, dump_index;
   logic        dump_valid, busy, done;
`ifdef RUN_WATCHDOG_EN
   logic        timeout;
`endif

   int checks = 0;
   int errors = 0;
   int mode = 0;   // 0: sequential, 1: jump to 200 at pc 8, 2: stuck pc

   always #5 clk = ~clk;

   function automatic logic [31:0] rval(input logic [4:0] i);
      return {8'hA5, 8'(i), 8'h3C, 3'b000, ~i};
   endfunction

   assign rf_rdata = rval(rf_raddr);

   always_comb begin
      case (mode)
         1:       pc_next = (pc_out == 32'd8) ? 32'd200 : pc_out + 32'd4;
         2:       pc_next = pc_out;
         default: pc_next = pc_out + 32'd4;
      endcase
   end

   run_dump_controller #(
      .INSTR_MAX(128),
      .REG_MAX(32),
      .DRAIN_CYCLES(4)
`ifdef RUN_WATCHDOG_EN
     ,.MAX_RUN_CYCLES(WD)
`endif
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .start(start),
      .pc_next(pc_next),
      .pc_out(pc_out),
      .rf_raddr(rf_raddr),
      .rf_rdata(rf_rdata),
      .dump_valid(dump_valid),
      .dump_ready(dump_ready),
      .dump_data(dump_data),
      .dump_index(dump_index),
      .busy(busy),
      .done(done)
`ifdef RUN_WATCHDOG_EN
     ,.timeout(timeout)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done();
      int n = 0;
      while (done !== 1'b1 && n < 300) begin
         tick();
         n++;
      end
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL wait_done got %b exp 1", done);
      end
   endtask

   task automatic wait_word(input logic [4:0] want);
      int n = 0;
      while (!(dump_valid === 1'b1 && dump_index === want) && n < 300) begin
         tick();
         n++;
      end
      checks++;
      if (dump_index !== want || dump_valid !== 1'b1) begin
         errors++;
         $display("FAIL wait_word got idx %0d valid %b exp idx %0d valid 1",
                  dump_index, dump_valid, want);
      end
   endtask

   task automatic test_reset();
      #2;
      checks++;
      if ({pc_out, rf_raddr, dump_valid, dump_data, dump_index, busy, done} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got pc %h ra %h v %b d %h i %h b %b dn %b exp all 0",
                  pc_out, rf_raddr, dump_valid, dump_data, dump_index, busy, done);
      end
`ifdef RUN_WATCHDOG_EN
      checks++;
      if (timeout !== 1'b0) begin
         errors++;
         $display("FAIL reset_timeout got %b exp 0", timeout);
      end
`endif
      tick();
      rst_n = 1'b1;
      tick();
      tick();
      checks++;
      if ({busy, done, pc_out} !== {1'b0, 1'b0, 32'd0}) begin
         errors++;
         $display("FAIL reset_idle got b %b dn %b pc %h exp 0 0 0", busy, done, pc_out);
      end
   endtask

   task automatic test_full_run();
      mode = 0;
      dump_ready = 1'b1;
      pulse_start();
      checks++;
      if (done !== 1'b0) begin
         errors++;
         $display("FAIL run_done_clr got %b exp 0", done);
      end
`ifdef RUN_WATCHDOG_EN
      checks++;
      if (timeout !== 1'b0) begin
         errors++;
         $display("FAIL run_timeout got %b exp 0", timeout);
      end
`endif
      for (int k = 0; k < 32; k++) begin
         checks++;
         if ({pc_out, busy, done} !== {32'(4 * k), 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL run_pc[%0d] got pc %h b %b dn %b exp pc %h b 1 dn 0",
                     k, pc_out, busy, done, 32'(4 * k));
         end
         tick();
      end
      for (int d = 0; d < 4; d++) begin
         checks++;
         if ({pc_out, busy, dump_valid} !== {32'd124, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL drain[%0d] got pc %h b %b v %b exp pc 7c b 1 v 0",
                     d, pc_out, busy, dump_valid);
         end
         tick();
      end
      checks++;
      if ({dump_valid, rf_raddr} !== {1'b0, 5'd0}) begin
         errors++;
         $display("FAIL dump_entry got v %b ra %0d exp v 0 ra 0", dump_valid, rf_raddr);
      end
      tick();
      for (int i = 0; i < 32; i++) begin
         checks++;
         if ({dump_valid, dump_index, dump_data} !== {1'b1, 5'(i), rval(5'(i))}) begin
            errors++;
            $display("FAIL dump_word[%0d] got v %b i %0d d %h exp v 1 i %0d d %h",
                     i, dump_valid, dump_index, dump_data, i, rval(5'(i)));
         end
         tick();
      end
      checks++;
      if ({dump_valid, busy, done, pc_out} !== {1'b0, 1'b0, 1'b1, 32'd124}) begin
         errors++;
         $display("FAIL run_end got v %b b %b dn %b pc %h exp v 0 b 0 dn 1 pc 7c",
                  dump_valid, busy, done, pc_out);
      end
   endtask

   task automatic test_backpressure();
      mode = 0;
      dump_ready = 1'b1;
      pulse_start();
      wait_word(5'd5);
      dump_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         tick();
         checks++;
         if ({dump_valid, dump_index, dump_data} !== {1'b1, 5'd5, rval(5'd5)}) begin
            errors++;
            $display("FAIL bp_hold[%0d] got v %b i %0d d %h exp v 1 i 5 d %h",
                     c, dump_valid, dump_index, dump_data, rval(5'd5));
         end
      end
      dump_ready = 1'b1;
      tick();
      checks++;
      if ({dump_valid, dump_index, dump_data} !== {1'b1, 5'd6, rval(5'd6)}) begin
         errors++;
         $display("FAIL bp_resume got v %b i %0d d %h exp v 1 i 6 d %h",
                  dump_valid, dump_index, dump_data, rval(5'd6));
      end
      wait_done();
   endtask

   task automatic test_jump();
      logic [31:0] exp_pc [4] = '{32'd0, 32'd4, 32'd8, 32'd200};
      mode = 1;
      dump_ready = 1'b1;
      pulse_start();
      for (int k = 0; k < 4; k++) begin
         checks++;
         if ({pc_out, busy} !== {exp_pc[k], 1'b1}) begin
            errors++;
            $display("FAIL jump_pc[%0d] got pc %0d b %b exp pc %0d b 1",
                     k, pc_out, busy, exp_pc[k]);
         end
         tick();
      end
      for (int d = 0; d < 4; d++) begin
         checks++;
         if ({pc_out, dump_valid} !== {32'd200, 1'b0}) begin
            errors++;
            $display("FAIL jump_drain[%0d] got pc %0d v %b exp pc 200 v 0",
                     d, pc_out, dump_valid);
         end
         tick();
      end
      wait_done();
      checks++;
      if (pc_out !== 32'd200) begin
         errors++;
         $display("FAIL jump_held got pc %0d exp 200", pc_out);
      end
      mode = 0;
   endtask

   task automatic test_reset_mid_dump();
      mode = 0;
      dump_ready = 1'b1;
      pulse_start();
      wait_word(5'd10);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({pc_out, rf_raddr, dump_valid, dump_data, dump_index, busy, done} !== '0) begin
         errors++;
         $display("FAIL async_reset got pc %h ra %h v %b d %h i %h b %b dn %b exp all 0",
                  pc_out, rf_raddr, dump_valid, dump_data, dump_index, busy, done);
      end
      tick();
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) tick();
      checks++;
      if ({busy, done, pc_out, dump_valid} !== {1'b0, 1'b0, 32'd0, 1'b0}) begin
         errors++;
         $display("FAIL post_reset_idle got b %b dn %b pc %h v %b exp 0 0 0 0",
                  busy, done, pc_out, dump_valid);
      end
   endtask

   task automatic test_start_in_dump();
      mode = 0;
      dump_ready = 1'b1;
      pulse_start();
      wait_word(5'd3);
      pulse_start();
      checks++;
      if ({dump_valid, dump_index, dump_data, busy} !== {1'b1, 5'd4, rval(5'd4), 1'b1}) begin
         errors++;
         $display("FAIL start_ignored got v %b i %0d d %h b %b exp v 1 i 4 d %h b 1",
                  dump_valid, dump_index, dump_data, busy, rval(5'd4));
      end
      wait_done();
      test_full_run();
   endtask

`ifdef RUN_WATCHDOG_EN
   task automatic test_watchdog();
      mode = 2;
      dump_ready = 1'b1;
      pulse_start();
      for (int k = 0; k < WD; k++) begin
         checks++;
         if ({pc_out, busy, timeout} !== {32'd0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL wd_run[%0d] got pc %h b %b to %b exp 0 1 0",
                     k, pc_out, busy, timeout);
         end
         tick();
      end
      checks++;
      if ({timeout, busy, dump_valid} !== {1'b1, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL wd_fire got to %b b %b v %b exp 1 1 0", timeout, busy, dump_valid);
      end
      wait_word(5'd0);
      for (int i = 0; i < 32; i++) begin
         checks++;
         if ({dump_valid, dump_index, dump_data} !== {1'b1, 5'(i), rval(5'(i))}) begin
            errors++;
            $display("FAIL wd_word[%0d] got v %b i %0d d %h exp v 1 i %0d d %h",
                     i, dump_valid, dump_index, dump_data, i, rval(5'(i)));
         end
         tick();
      end
      checks++;
      if ({done, timeout} !== {1'b1, 1'b1}) begin
         errors++;
         $display("FAIL wd_done got dn %b to %b exp 1 1", done, timeout);
      end
      mode = 0;
      test_full_run();
   endtask
`endif

   initial begin
      test_reset();
      test_full_run();
      test_backpressure();
      test_jump();
      test_reset_mid_dump();
      test_start_in_dump();
`ifdef RUN_WATCHDOG_EN
      test_watchdog();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
